// File: rtl/vending_pkg.sv
// Shared types for the multi-product vending controller.
// State encoding, coin_type / change_coin encodings and the coin value lookup.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VEND,
    CHANGE
  } state_t;

  typedef enum logic [1:0] {
    COIN_5   = 2'd0,
    COIN_10  = 2'd1,
    COIN_20  = 2'd2,
    COIN_BAD = 2'd3
  } coin_type_t;

  typedef enum logic {
    CHG_5  = 1'b0,
    CHG_10 = 1'b1
  } change_coin_t;

  // Coin value in 5 rs units; an invalid coin is worth nothing.
  function automatic logic [2:0] coin_units(input coin_type_t ct);
    case (ct)
      COIN_5:  return 3'd1;
      COIN_10: return 3'd2;
      COIN_20: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Front-end / actuator signal bundle for vending_machine_multi.
// slave : the controller (takes coins, keypad, restock, hopper ready; drives credit,
//         pulses, dispense and change handshake).
// master: the surrounding front end / actuators.
interface vending_machine_multi_if #(
  parameter int unsigned NUM_ITEMS = 4,
  parameter int unsigned CREDIT_W  = 6
);
  localparam int unsigned ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                sel_valid;
  logic [ITEM_W-1:0]   sel_item;
  logic                cancel;
  logic                restock_valid;
  logic [ITEM_W-1:0]   restock_item;
  logic                change_ready;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                vend_valid;
  logic [ITEM_W-1:0]   vend_item;
  logic                sold_out;
  logic                low_credit;
  logic                change_valid;
  logic                change_coin;
  logic                busy;

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel_item, cancel,
           restock_valid, restock_item, change_ready,
    output credit, coin_reject, vend_valid, vend_item, sold_out,
           low_credit, change_valid, change_coin, busy
  );

  modport master (
    output coin_valid, coin_type, sel_valid, sel_item, cancel,
           restock_valid, restock_item, change_ready,
    input  credit, coin_reject, vend_valid, vend_item, sold_out,
           low_credit, change_valid, change_coin, busy
  );

endinterface

// File: rtl/vm_change_dispenser.sv
// Change/refund coin sequencer.
// load/value : capture the remainder (units) to pay out.
// active     : controller is in CHANGE; coins are offered only then.
// ready      : hopper accepts the offered coin.
// valid/coin : offered coin (CHG_10 while remainder >= 2, else CHG_5).
// pending    : remainder still nonzero.
// done       : this cycle's transfer empties the remainder.
module vm_change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] value,
  input  logic                active,
  input  logic                ready,
  output logic                valid,
  output logic                coin,
  output logic                pending,
  output logic                done
);

  logic [CREDIT_W-1:0] remainder;
  logic [CREDIT_W-1:0] step;
  logic                take;

  // Outputs decode only the remainder register and the registered state,
  // so they stay stable until the hopper takes the coin.
  assign pending = (remainder != '0);
  assign valid   = active && pending;
  assign coin    = (valid && remainder >= CREDIT_W'(2)) ? CHG_10 : CHG_5;
  assign step    = (remainder >= CREDIT_W'(2)) ? CREDIT_W'(2) : CREDIT_W'(1);
  assign take    = valid && ready;
  assign done    = take && (remainder == step);

  always_ff @(posedge clk) begin
    if (!rst) begin
      remainder <= '0;
    end else if (load) begin
      remainder <= value;
    end else if (take) begin
      remainder <= remainder - step;
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller.
// clk, rst (sync, active-low) plus the vending_machine_multi_if slave bundle:
// coin/keypad/restock/hopper-ready in; credit, reject/vend/sold_out/low_credit
// pulses, change handshake and busy out.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned CREDIT_W   = 6,
  // Item prices: item 0 = 3, item 1 = 3, item 2 = 2, item 3 = 4 (item 0 at LSBs).
  parameter logic [4*NUM_ITEMS-1:0] PRICES = {4'd4, 4'd2, 4'd3, 4'd3},
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned INIT_STOCK = 10,
  parameter int unsigned MAX_CREDIT = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  vending_machine_multi_if.slave bus
);

  localparam int unsigned ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

  state_t              state, state_next;
  logic [CREDIT_W-1:0] credit, credit_next;
  logic [STOCK_W-1:0]  stock      [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_next [NUM_ITEMS];
  logic                coin_reject, coin_reject_next;
  logic                vend_valid, vend_valid_next;
  logic [ITEM_W-1:0]   vend_item, vend_item_next;
  logic                sold_out, sold_out_next;
  logic                low_credit, low_credit_next;
  logic                vend_take;

  logic                sel_ok;
  logic [STOCK_W-1:0]  sel_stock;
  logic [3:0]          sel_price;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_ok;

  logic                chg_load;
  logic [CREDIT_W-1:0] chg_value;
  logic                chg_valid, chg_coin, chg_pending, chg_done;

  vm_change_dispenser #(.CREDIT_W(CREDIT_W)) u_change (
    .clk     (clk),
    .rst     (rst),
    .load    (chg_load),
    .value   (chg_value),
    .active  (state == CHANGE),
    .ready   (bus.change_ready),
    .valid   (chg_valid),
    .coin    (chg_coin),
    .pending (chg_pending),
    .done    (chg_done)
  );

  // Looked-up stock/price of the selected item; out-of-range items match nothing
  // and are therefore reported as sold out.
  always_comb begin
    sel_ok    = 1'b0;
    sel_stock = '0;
    sel_price = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (bus.sel_item == ITEM_W'(i)) begin
        sel_ok    = 1'b1;
        sel_stock = stock[i];
        sel_price = PRICES[4*i +: 4];
      end
    end
  end

  assign credit_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_units(coin_type_t'(bus.coin_type)));
  assign coin_ok    = (bus.coin_type != COIN_BAD) &&
                      (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_comb begin
    state_next       = state;
    credit_next      = credit;
    coin_reject_next = 1'b0;
    vend_valid_next  = 1'b0;
    vend_item_next   = vend_item;
    sold_out_next    = 1'b0;
    low_credit_next  = 1'b0;
    vend_take        = 1'b0;
    chg_load         = 1'b0;
    chg_value        = '0;
    case (state)
      IDLE: begin
        if (bus.cancel) begin
          coin_reject_next = bus.coin_valid;
          if (credit != '0) begin
            chg_load    = 1'b1;
            chg_value   = credit;
            credit_next = '0;
            state_next  = CHANGE;
          end
        end else if (bus.sel_valid) begin
          coin_reject_next = bus.coin_valid;
          if (!sel_ok || sel_stock == '0) begin
            sold_out_next = 1'b1;
          end else if ({1'b0, credit} < (CREDIT_W+1)'(sel_price)) begin
            low_credit_next = 1'b1;
          end else begin
            vend_take       = 1'b1;
            chg_load        = 1'b1;
            chg_value       = credit - CREDIT_W'(sel_price);
            credit_next     = '0;
            vend_valid_next = 1'b1;
            vend_item_next  = bus.sel_item;
            state_next      = VEND;
          end
        end else if (bus.coin_valid) begin
          if (coin_ok) begin
            credit_next = credit_sum[CREDIT_W-1:0];
          end else begin
            coin_reject_next = 1'b1;
          end
        end
      end
      VEND: begin
        coin_reject_next = bus.coin_valid;
        state_next       = chg_pending ? CHANGE : IDLE;
      end
      CHANGE: begin
        coin_reject_next = bus.coin_valid;
        if (chg_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Restock is applied after the vend decrement so it wins on a shared item.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      stock_next[i] = stock[i];
      if (vend_take && bus.sel_item == ITEM_W'(i) && stock[i] != '0) begin
        stock_next[i] = stock[i] - STOCK_W'(1);
      end
      if (bus.restock_valid && bus.restock_item == ITEM_W'(i)) begin
        stock_next[i] = STOCK_W'(INIT_STOCK);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      credit      <= '0;
      coin_reject <= 1'b0;
      vend_valid  <= 1'b0;
      vend_item   <= '0;
      sold_out    <= 1'b0;
      low_credit  <= 1'b0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      state       <= state_next;
      credit      <= credit_next;
      coin_reject <= coin_reject_next;
      vend_valid  <= vend_valid_next;
      vend_item   <= vend_item_next;
      sold_out    <= sold_out_next;
      low_credit  <= low_credit_next;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock[i] <= stock_next[i];
      end
    end
  end

  assign bus.credit       = credit;
  assign bus.coin_reject  = coin_reject;
  assign bus.vend_valid   = vend_valid;
  assign bus.vend_item    = vend_item;
  assign bus.sold_out     = sold_out;
  assign bus.low_credit   = low_credit;
  assign bus.change_valid = chg_valid;
  assign bus.change_coin  = chg_coin;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi: a transaction-level model predicts the
// outputs after every clock edge; a negedge monitor pops and compares them.
module tb_vending_machine_multi;

  localparam int unsigned NUM_ITEMS = 4;
  localparam int unsigned CREDIT_W  = 6;

  typedef struct packed {
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       restock_valid;
    logic [1:0] restock_item;
    logic       ready;
  } in_t;

  typedef struct packed {
    logic [5:0] credit;
    logic       rej;
    logic       vv;
    logic [1:0] vi;
    logic       so;
    logic       lc;
    logic       cv;
    logic       cc;
    logic       busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vending_machine_multi_if #(.NUM_ITEMS(NUM_ITEMS), .CREDIT_W(CREDIT_W)) bus ();

  vending_machine_multi #(
    .NUM_ITEMS (NUM_ITEMS),
    .CREDIT_W  (CREDIT_W),
    .PRICES    ({4'd4, 4'd2, 4'd3, 4'd3}),
    .STOCK_W   (4),
    .INIT_STOCK(10),
    .MAX_CREDIT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: credit, stock per item, change owed as a queue of coins,
  // and whether the dispense pulse is currently showing.
  int unsigned price [NUM_ITEMS] = '{3, 3, 2, 4};
  int unsigned m_credit;
  int unsigned m_stock [NUM_ITEMS];
  bit          m_chg [$];
  bit          m_vending;

  obs_t sb_q [$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_on      = 1'b1;

  task automatic load_change(input int unsigned r);
    while (r >= 2) begin
      m_chg.push_back(1'b1);
      r -= 2;
    end
    if (r != 0) m_chg.push_back(1'b0);
  endtask

  task automatic apply(input in_t v);
    obs_t e;
    int unsigned val;
    rst               = v.rst;
    bus.coin_valid    = v.coin_valid;
    bus.coin_type     = v.coin_type;
    bus.sel_valid     = v.sel_valid;
    bus.sel_item      = v.sel_item;
    bus.cancel        = v.cancel;
    bus.restock_valid = v.restock_valid;
    bus.restock_item  = v.restock_item;
    bus.change_ready  = v.ready;
    e = '0;
    if (!v.rst) begin
      m_credit = 0;
      foreach (m_stock[i]) m_stock[i] = 10;
      m_chg.delete();
      m_vending = 1'b0;
    end else begin
      if (m_vending) begin
        m_vending = 1'b0;
        e.rej = v.coin_valid;
      end else if (m_chg.size() > 0) begin
        e.rej = v.coin_valid;
        if (v.ready) void'(m_chg.pop_front());
      end else if (v.cancel) begin
        e.rej = v.coin_valid;
        if (m_credit > 0) begin
          load_change(m_credit);
          m_credit = 0;
        end
      end else if (v.sel_valid) begin
        e.rej = v.coin_valid;
        if (m_stock[v.sel_item] == 0) e.so = 1'b1;
        else if (m_credit < price[v.sel_item]) e.lc = 1'b1;
        else begin
          m_stock[v.sel_item]--;
          load_change(m_credit - price[v.sel_item]);
          m_credit  = 0;
          m_vending = 1'b1;
          e.vv = 1'b1;
          e.vi = v.sel_item;
        end
      end else if (v.coin_valid) begin
        case (v.coin_type)
          2'd0: val = 1;
          2'd1: val = 2;
          2'd2: val = 4;
          default: val = 0;
        endcase
        if (val == 0 || m_credit + val > 20) e.rej = 1'b1;
        else m_credit += val;
      end
      if (v.restock_valid) m_stock[v.restock_item] = 10;
    end
    e.credit = 6'(m_credit);
    e.busy   = m_vending || (m_chg.size() > 0);
    e.cv     = !m_vending && (m_chg.size() > 0);
    if (e.cv) e.cc = m_chg[0];
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  function automatic in_t nop(input logic rdy = 1'b0);
    in_t v;
    v = '0;
    v.rst = 1'b1;
    v.ready = rdy;
    return v;
  endfunction

  task automatic idle(input int n, input logic rdy = 1'b0);
    for (int i = 0; i < n; i++) apply(nop(rdy));
  endtask

  task automatic coin(input int t);
    in_t v;
    v = nop();
    v.coin_valid = 1'b1;
    v.coin_type = 2'(t);
    apply(v);
  endtask

  task automatic sel(input int item, input logic rdy = 1'b0);
    in_t v;
    v = nop(rdy);
    v.sel_valid = 1'b1;
    v.sel_item = 2'(item);
    apply(v);
  endtask

  task automatic cancel_req(input logic rdy = 1'b0);
    in_t v;
    v = nop(rdy);
    v.cancel = 1'b1;
    apply(v);
  endtask

  task automatic restock(input int item);
    in_t v;
    v = nop();
    v.restock_valid = 1'b1;
    v.restock_item = 2'(item);
    apply(v);
  endtask

  task automatic do_reset(input int n);
    in_t v;
    v = nop();
    v.rst = 1'b0;
    for (int i = 0; i < n; i++) apply(v);
  endtask

  always @(negedge clk) begin
    if (mon_on && sb_q.size() > 0) begin
      obs_t e, got;
      e = sb_q.pop_front();
      got.credit = bus.credit;
      got.rej    = bus.coin_reject;
      got.vv     = bus.vend_valid;
      got.vi     = bus.vend_valid ? bus.vend_item : 2'd0;
      got.so     = bus.sold_out;
      got.lc     = bus.low_credit;
      got.cv     = bus.change_valid;
      got.cc     = bus.change_valid ? bus.change_coin : 1'b0;
      got.busy   = bus.busy;
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL outputs vec %0d t=%0t: got credit=%0d rej=%b vend=%b/%0d so=%b lc=%b cv=%b cc=%b busy=%b; expected credit=%0d rej=%b vend=%b/%0d so=%b lc=%b cv=%b cc=%b busy=%b",
                 vectors, $time, got.credit, got.rej, got.vv, got.vi, got.so, got.lc, got.cv, got.cc, got.busy,
                 e.credit, e.rej, e.vv, e.vi, e.so, e.lc, e.cv, e.cc, e.busy);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, scoreboard depth %0d, required 0", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    do_reset(2);

    // 10 rs + 5 rs, buy item 0 (price 3): exact credit, no change.
    coin(1); coin(0); sel(0); idle(2);

    // 20 rs + 10 rs, buy item 2 (price 2): two 10 rs change coins.
    coin(2); coin(1); sel(2, 1'b1); idle(4, 1'b1);

    // Credit 5, cancel with the hopper stalled for three cycles.
    coin(2); coin(0); cancel_req(1'b0); idle(3, 1'b0); idle(5, 1'b1);

    // Drain item 3, hit sold out, restock, buy again.
    for (int i = 0; i < 10; i++) begin
      coin(2); sel(3); idle(1);
    end
    coin(2); sel(3); idle(1); restock(3); sel(3); idle(2);

    // Credit ceiling, invalid coin, coin colliding with a selection.
    coin(2); coin(2); coin(2); coin(2); coin(1); coin(0);
    coin(1); coin(3);
    v = nop(1'b1);
    v.coin_valid = 1'b1; v.coin_type = 2'd0;
    v.sel_valid = 1'b1; v.sel_item = 2'd1;
    apply(v);
    idle(12, 1'b1);

    // Reset in the middle of a 3-unit refund.
    coin(1); coin(0); cancel_req(1'b0); idle(1, 1'b0);
    do_reset(1); idle(2, 1'b1); sel(3); idle(1);

    for (int n = 0; n < 3000; n++) begin
      v = '0;
      v.rst           = ($urandom_range(199) != 0);
      v.coin_valid    = ($urandom_range(9) < 4);
      v.coin_type     = 2'($urandom_range(3));
      v.sel_valid     = ($urandom_range(9) < 2);
      v.sel_item      = 2'($urandom_range(3));
      v.cancel        = ($urandom_range(29) == 0);
      v.restock_valid = ($urandom_range(39) == 0);
      v.restock_item  = 2'($urandom_range(3));
      v.ready         = ($urandom_range(9) < 6);
      apply(v);
    end

    @(negedge clk);
    #1;
    mon_on = 1'b0;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected records left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
